// File: rtl/system_mdr_pkg.sv
// Shared MDR system constants: result width, display digit count, display FSM
// state codes and active-low seven-segment patterns ({g,f,e,d,c,b,a}).
package system_mdr_pkg;

   localparam int unsigned DW = 16;
   // floor(DW*log10(2))+1 decimal digits cover 2^DW-1 (2^DW is never a power of ten)
   localparam int unsigned DIGITS = (DW * 30103) / 100000 + 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_CONV   = 2'd1;
   localparam logic [1:0] ST_UPDATE = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      CONV   = ST_CONV,
      UPDATE = ST_UPDATE
   } disp_state_e;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_R     = 7'h2F;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment code; blank_i forces all
// segments off. Non-decimal codes also display blank.
module seg7_decoder
   import system_mdr_pkg::*;
(
   input  logic [3:0] bcd_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      if (!blank_i) begin
         case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/result_display.sv
// Result to seven-segment display: sequential double-dabble conversion, leading
// zero blanking and held outputs. DISPLAY_SIGN_EN treats i_result as signed.
module result_display
   import system_mdr_pkg::*;
#(
   parameter int unsigned DW     = system_mdr_pkg::DW,
   parameter int unsigned DIGITS = system_mdr_pkg::DIGITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DW-1:0]         i_result,
   input  logic                  i_valid,
   input  logic                  i_error,
   output logic [7*DIGITS-1:0]   o_seg,
   output logic                  o_neg,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

   disp_state_e             state_q, state_d;
   logic [DW-1:0]           bin_q, bin_d;
   logic [4*DIGITS-1:0]     bcd_q, bcd_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    sign_q, sign_d;
   logic [7*DIGITS-1:0]     seg_q, seg_d;
   logic                    neg_q, neg_d;
   logic                    done_q, done_d;

   logic [DW-1:0]           mag;
   logic                    neg_in;
   logic [4*DIGITS-1:0]     bcd_adj;
   logic [4*DIGITS-1:0]     shift_bcd;
   logic [DIGITS-1:0]       blank;
   logic [7*DIGITS-1:0]     dec_seg;
   logic [7*DIGITS-1:0]     err_seg;

`ifdef DISPLAY_SIGN_EN
   // Negating the most negative value wraps to 2^(DW-1), which is the correct magnitude
   assign neg_in = i_result[DW-1];
   assign mag    = neg_in ? ('0 - i_result) : i_result;
`else
   assign neg_in = 1'b0;
   assign mag    = i_result;
`endif

   always_comb begin
      bcd_adj = bcd_q;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5) begin
            bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
         end
      end
   end

   assign shift_bcd = {bcd_adj[4*DIGITS-2:0], bin_q[DW-1]};

   // Decoders see the post-shift BCD so the final iteration's digits register directly
   always_comb begin
      logic seen;
      seen  = 1'b0;
      blank = '0;
      for (int unsigned k = DIGITS - 1; k > 0; k--) begin
         seen     = seen | (shift_bcd[4*k +: 4] != 4'd0);
         blank[k] = ~seen;
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_dec
      seg7_decoder u_dec (
         .bcd_i   (shift_bcd[4*g +: 4]),
         .blank_i (blank[g]),
         .seg_o   (dec_seg[7*g +: 7])
      );
   end

   always_comb begin
      err_seg         = {DIGITS{SEG_BLANK}};
      err_seg[14 +: 7] = SEG_E;
      err_seg[7 +: 7]  = SEG_R;
      err_seg[0 +: 7]  = SEG_R;
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      seg_d   = seg_q;
      neg_d   = neg_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_valid) begin
               if (i_error) begin
                  seg_d   = err_seg;
                  neg_d   = 1'b0;
                  done_d  = 1'b1;
                  state_d = UPDATE;
               end else begin
                  bin_d   = mag;
                  sign_d  = neg_in;
                  bcd_d   = '0;
                  cnt_d   = '0;
                  state_d = CONV;
               end
            end
         end
         CONV: begin
            bcd_d = shift_bcd;
            bin_d = {bin_q[DW-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
               seg_d   = dec_seg;
               neg_d   = sign_q;
               done_d  = 1'b1;
               state_d = UPDATE;
            end
         end
         UPDATE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
         seg_q   <= {DIGITS{SEG_BLANK}};
         neg_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
         seg_q   <= seg_d;
         neg_q   <= neg_d;
         done_q  <= done_d;
      end
   end

   assign o_seg  = seg_q;
   assign o_neg  = neg_q;
   assign o_busy = (state_q != IDLE);
   assign o_done = done_q;

endmodule

// File: tb/tb_result_display.sv
// Self-checking bench for result_display (DW=16, DIGITS=5); honours DISPLAY_SIGN_EN.
module tb_result_display;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] i_result;
   logic        i_valid;
   logic        i_error;
   logic [34:0] o_seg;
   logic        o_neg;
   logic        o_busy;
   logic        o_done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   result_display #(.DW(16), .DIGITS(5)) dut (
      .clk      (clk),
      .rst      (rst),
      .i_result (i_result),
      .i_valid  (i_valid),
      .i_error  (i_error),
      .o_seg    (o_seg),
      .o_neg    (o_neg),
      .o_busy   (o_busy),
      .o_done   (o_done)
   );

   function automatic logic [6:0] digit_code(input int unsigned d);
      case (d)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
         8: return 7'h00;  default: return 7'h10;
      endcase
   endfunction

   function automatic int unsigned model_mag(input logic [15:0] r);
`ifdef DISPLAY_SIGN_EN
      if (r[15]) return 32'd65536 - int'(r);
`endif
      return int'(r);
   endfunction

   function automatic logic model_neg(input logic [15:0] r, input logic err);
`ifdef DISPLAY_SIGN_EN
      return r[15] && !err;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [34:0] model_seg(input logic [15:0] r, input logic err);
      logic [34:0] s;
      int unsigned mag, p;
      if (err) return {7'h7F, 7'h7F, 7'h06, 7'h2F, 7'h2F};
      mag = model_mag(r);
      p = 1;
      for (int unsigned k = 0; k < 5; k++) begin
         if (k > 0 && mag < p) s[7*k +: 7] = 7'h7F;
         else                  s[7*k +: 7] = digit_code((mag / p) % 10);
         p = p * 10;
      end
      return s;
   endfunction

   // Pulse i_valid for one edge (edge N); returns the cycle index of o_done (0 = timeout)
   task automatic run_result(input logic [15:0] r, input logic err, output int lat);
      @(negedge clk);
      i_result = r; i_error = err; i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
      lat = 0;
      for (int c = 1; c <= 40; c++) begin
         if (o_done) begin
            lat = c;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; i_valid = 1'b0; i_error = 1'b0; i_result = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (o_seg !== {5{7'h7F}} || o_neg !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
         errors++;
         $display("FAIL reset: seg=%h neg=%b busy=%b done=%b required seg=%h neg=0 busy=0 done=0",
                  o_seg, o_neg, o_busy, o_done, {5{7'h7F}});
      end
   endtask

   task automatic check_result(input string name, input logic [15:0] r, input logic err);
      int lat;
      int exp_lat;
      exp_lat = err ? 1 : 17;
      run_result(r, err, lat);
      checks++;
      if (lat !== exp_lat) begin
         errors++;
         $display("FAIL %s latency: got %0d required %0d (0 = timeout)", name, lat, exp_lat);
      end
      checks++;
      if (o_seg !== model_seg(r, err) || o_neg !== model_neg(r, err) || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL %s value r=%h err=%b: seg=%h neg=%b busy=%b required seg=%h neg=%b busy=1",
                  name, r, err, o_seg, o_neg, o_busy, model_seg(r, err), model_neg(r, err));
      end
      @(negedge clk);
      checks++;
      if (o_done !== 1'b0 || o_busy !== 1'b0 || o_seg !== model_seg(r, err)) begin
         errors++;
         $display("FAIL %s hold: done=%b busy=%b seg=%h required done=0 busy=0 seg=%h",
                  name, o_done, o_busy, o_seg, model_seg(r, err));
      end
   endtask

   task automatic test_known();
      check_result("dec1234", 16'd1234, 1'b0);
      checks++;
      if (o_seg !== {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19}) begin
         errors++;
         $display("FAIL dec1234_literal: seg=%h required %h", o_seg, {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19});
      end
      check_result("zero", 16'd0, 1'b0);
      check_result("allones", 16'hFFFF, 1'b0);
      check_result("msb_only", 16'h8000, 1'b0);
      check_result("ten", 16'd10, 1'b0);
   endtask

   task automatic test_error();
      check_result("error", 16'h1234, 1'b1);
      check_result("error_neg", 16'hFFFF, 1'b1);
   endtask

   task automatic test_random();
      logic [15:0] r;
      logic        e;
      for (int i = 0; i < 24; i++) begin
         r = 16'($urandom);
         if (i % 3 == 0) r = r >> $urandom_range(15, 4);
         e = ($urandom_range(7, 0) == 0);
         check_result("random", r, e);
      end
   endtask

   task automatic test_ignore_and_reset();
      int lat;
      int pulses;
      logic [34:0] prev;
      // second strobe during conversion is dropped
      @(negedge clk);
      i_result = 16'd4321; i_error = 1'b0; i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
      lat = 0;
      for (int c = 1; c <= 40; c++) begin
         if (c == 5) begin i_valid = 1'b1; i_result = 16'd999; end
         if (c == 6) i_valid = 1'b0;
         if (o_done) begin lat = c; break; end
         @(negedge clk);
      end
      checks++;
      if (lat != 17 || o_seg !== model_seg(16'd4321, 1'b0)) begin
         errors++;
         $display("FAIL ignore_during_conv: lat=%0d seg=%h required lat=17 seg=%h",
                  lat, o_seg, model_seg(16'd4321, 1'b0));
      end
      // strobe in the UPDATE cycle is dropped too
      i_valid = 1'b1; i_result = 16'd777;
      @(negedge clk);
      i_valid = 1'b0;
      prev = o_seg;
      repeat (3) @(negedge clk);
      checks++;
      if (o_busy !== 1'b0 || o_seg !== model_seg(16'd4321, 1'b0)) begin
         errors++;
         $display("FAIL ignore_in_update: busy=%b seg=%h required busy=0 seg=%h",
                  o_busy, o_seg, model_seg(16'd4321, 1'b0));
      end
      // reset mid-conversion, asserted together with a strobe
      @(negedge clk);
      i_result = 16'd5555; i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
      for (int c = 1; c < 8; c++) @(negedge clk);
      rst = 1'b1; i_valid = 1'b1; i_result = 16'd1;
      @(negedge clk);
      checks++;
      if (o_seg !== {5{7'h7F}} || o_neg !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_conv: seg=%h neg=%b busy=%b done=%b required all-blank, 0,0,0",
                  o_seg, o_neg, o_busy, o_done);
      end
      @(negedge clk);
      rst = 1'b0; i_valid = 1'b0;
      pulses = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (o_done || o_busy) pulses++;
      end
      checks++;
      if (pulses != 0 || o_seg !== {5{7'h7F}}) begin
         errors++;
         $display("FAIL reset_discard: activity_cycles=%0d seg=%h required 0 and all-blank (prev %h)",
                  pulses, o_seg, prev);
      end
   endtask

   task automatic test_back_to_back();
      check_result("b2b_first", 16'd60000, 1'b0);
      check_result("b2b_second", 16'd7, 1'b0);
      check_result("b2b_err", 16'd0, 1'b1);
      check_result("b2b_after_err", 16'd100, 1'b0);
   endtask

   initial begin
      test_reset();
      test_known();
      test_error();
      test_random();
      test_ignore_and_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/result_display.md
# result_display

Output-side block of the MDR system: accepts a finished result from the multiply/divide/square-root datapath and drives the board's seven-segment displays. It is the user-facing counterpart of the switch input stage.

- Converts a DW-bit result to decimal with a sequential shift-and-add-3 (double dabble) engine.
- Blanks leading zeros and encodes each digit to active-low segments.
- Holds the displayed value until the next result arrives.

## Interface
Parameters:
- DW, 16: result width; taken from system_mdr_pkg.
- DIGITS, 5: number of decimal digits driven. Must satisfy 10^DIGITS > 2^DW − 1.

Ports (one clock; reset is synchronous and active-high):
- clk, input, 1: system clock; all state changes on its rising edge.
- rst, input, 1: synchronous active-high reset.
- i_result, input, DW: result word from the datapath.
- i_valid, input, 1: single-cycle strobe meaning i_result / i_error are valid.
- i_error, input, 1: datapath error (division by zero, root of negative).
- o_seg, output, 7*DIGITS: active-low segments.
  - Digit k occupies bits [7k+6:7k], bit order {g,f,e,d,c,b,a}.
  - Digit 0 is the units digit.
- o_neg, output, 1: minus-sign indicator, active-high.
- o_busy, output, 1: high while a conversion is in progress.
- o_done, output, 1: one-cycle pulse when o_seg / o_neg take a new value.

## Operation
States:
- IDLE → CONV: on i_valid with i_error=0.
  - Loads the magnitude into the shift register.
  - Latches a pending sign and clears the BCD register.
- IDLE → UPDATE: on i_valid with i_error=1 (conversion skipped).
- CONV: one shift-and-add-3 iteration per cycle.
  - Before each shift, every BCD nibble ≥ 5 gets +3.
  - Bit counter runs 0..DW−1; after DW iterations → UPDATE.
- UPDATE → IDLE: unconditionally after one cycle.

Segment codes (active-low):
- Digits 0..9: 40,79,24,30,19,12,02,78,00,10 hex.
- Blank: 7F. 'E': 06. 'r': 2F.

Leading-zero blanking:
- Every digit above the most significant nonzero digit shows blank.
- Digit 0 always shows a numeral, so a zero result displays "0".

Error display:
- Digits 2,1,0 show E,r,r; all other digits blank.
- o_neg=0.

Input handling:
- i_valid is ignored outside IDLE; there is no queue and no backpressure.
- Outputs hold their last value indefinitely; the display is cleared only by reset.

## Timing
Latency, with i_valid sampled high at edge N:
- o_busy is high from cycle N+1 through the UPDATE cycle.
- Normal result: CONV occupies cycles N+1..N+DW; UPDATE is cycle N+DW+1.
  - o_done=1 in that cycle, and o_seg / o_neg show the new value from that cycle on.
- Error: UPDATE is cycle N+1.
- With DW=16, a normal result gives o_done in cycle N+17.

Reset values:
- o_seg all 7F (all blank), o_neg=0, o_busy=0, o_done=0, state IDLE.

Boundary conditions:
- Reset asserted during CONV or UPDATE: reset values apply at the next edge; the partial conversion is discarded and o_done is not pulsed.
- i_valid in the UPDATE cycle is ignored. A new result is accepted starting the cycle after UPDATE, i.e. one idle cycle between back-to-back results.
- i_valid and rst both high: reset wins.

## Configuration
Macro DISPLAY_SIGN_EN. With it defined:
- i_result is two's complement.
- If the MSB is set, the magnitude is −i_result computed in DW bits; −2^(DW−1) gives magnitude 2^(DW−1), unsigned with no overflow.
- o_neg=1 for negative non-error results.

Without it:
- i_result is unsigned.
- o_neg is tied to 0.

## Structure
Shared package (system_mdr_pkg):
- DW, and a DIGITS constant derived from DW.
- Display state enum: IDLE, CONV, UPDATE.
- Segment code localparams: digits 0–9, blank, 'E', 'r'.

Sub-module seg7_decoder:
- Combinational: 4-bit BCD plus blank flag → 7-bit active-low code.
- DIGITS instances in a generate loop.

The double-dabble engine, bit counter, blanking logic and output registers live in result_display.

## Test plan
- i_result=1234 (0x04D2), i_valid pulse: o_done 17 cycles later. Digit3..0 = 79,24,30,19 (1,2,3,4), digit4 = 7F, o_neg=0.
- i_result=0: digit0 = 40; digits 1..4 = 7F.
- With DISPLAY_SIGN_EN, i_result=0xFFFF: o_neg=1, digit0 = 79 (1), rest blank. i_result=0x8000: o_neg=1, digits show 32768.
- Without DISPLAY_SIGN_EN, i_result=0xFFFF: digits show 65535, o_neg=0.
- i_error=1 with i_valid: o_done in cycle N+1, digits2..0 = 06,2F,2F, others 7F.
- Second i_valid at cycle N+5 during CONV: ignored, and the first result is displayed. Then rst at cycle N+8: no o_done pulse, all outputs at reset values from N+9.
